// File: rtl/aes_mix_columns.sv
// ---------------------------------------------------------------------------
// aes_mix_columns
//   AES MixColumns / InvMixColumns round stage with a registered output.
//   Each 32-bit column of the 128-bit state is multiplied by the fixed AES
//   matrix over GF(2^8) in a dedicated column unit. The forward or inverse
//   matrix is chosen per transfer. Latency is one cycle and a new state is
//   accepted every cycle.
//
// Ports
//   clk       in   1    rising-edge clock
//   rst       in   1    synchronous active-high reset
//   in_valid  in   1    dataIn / decrypt valid this cycle
//   decrypt   in   1    0 = MixColumns, 1 = InvMixColumns
//   dataIn    in   128  state, byte k = dataIn[127-8k -: 8], column-major
//   out_valid out  1    dataOut carries a new result this cycle
//   dataOut   out  128  transformed state, same byte mapping as dataIn
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// mixColumn
//   Purely combinational transform of one column (rows a0..a3, a0 in the
//   most significant byte).
//
// Ports
//   decrypt  in   1   0 = forward matrix, 1 = inverse matrix
//   colIn    in   32  column bytes {a0, a1, a2, a3}
//   colOut   out  32  transformed column, same byte order
// ---------------------------------------------------------------------------
module mixColumn (
    input  logic        decrypt,
    input  logic [31:0] colIn,
    output logic [31:0] colOut
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    logic [7:0] a   [4];
    logic [7:0] x2  [4];
    logic [7:0] x4  [4];
    logic [7:0] x8  [4];
    logic [7:0] m09 [4];
    logic [7:0] m0B [4];
    logic [7:0] m0D [4];
    logic [7:0] m0E [4];
    logic [7:0] fwd [4];
    logic [7:0] inv [4];

    for (genvar r = 0; r < 4; r++) begin : gRow
        assign a[r]   = colIn[31-8*r -: 8];

        // Three chained doublings give 2b, 4b and 8b; the inverse
        // coefficients are sums of these powers plus the byte itself.
        assign x2[r]  = xtime(a[r]);
        assign x4[r]  = xtime(x2[r]);
        assign x8[r]  = xtime(x4[r]);
        assign m09[r] = x8[r] ^ a[r];
        assign m0B[r] = x8[r] ^ x2[r] ^ a[r];
        assign m0D[r] = x8[r] ^ x4[r] ^ a[r];
        assign m0E[r] = x8[r] ^ x4[r] ^ x2[r];

        assign fwd[r] = x2[r] ^ (x2[(r+1)%4] ^ a[(r+1)%4])
                      ^ a[(r+2)%4] ^ a[(r+3)%4];
        assign inv[r] = m0E[r] ^ m0B[(r+1)%4] ^ m0D[(r+2)%4] ^ m09[(r+3)%4];

        assign colOut[31-8*r -: 8] = decrypt ? inv[r] : fwd[r];
    end

endmodule

module aes_mix_columns (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         decrypt,
    input  logic [127:0] dataIn,
    output logic         out_valid,
    output logic [127:0] dataOut
);

    logic [127:0] mixed;

    for (genvar c = 0; c < 4; c++) begin : gCol
        mixColumn uCol (
            .decrypt (decrypt),
            .colIn   (dataIn[127-32*c -: 32]),
            .colOut  (mixed[127-32*c -: 32])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dataOut   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                dataOut <= mixed;
            end
        end
    end

endmodule

// File: tb/tb_aes_mix_columns.sv
module tb_aes_mix_columns;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         decrypt;
    logic [127:0] dataIn;
    logic         out_valid;
    logic [127:0] dataOut;

    int checks;
    int errors;

    aes_mix_columns dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .decrypt   (decrypt),
        .dataIn    (dataIn),
        .out_valid (out_valid),
        .dataOut   (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic GF(2^8) multiply: carry-less product then polynomial division
    // by 0x11B.
    function automatic logic [7:0] gfMul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (y[i]) p = p ^ (16'(x) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // Matrix-times-column reference over all four columns.
    function automatic logic [127:0] refModel(input logic [127:0] s, input logic dec);
        logic [7:0]   coef [4];
        logic [7:0]   col  [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (dec) begin
            coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) col[r] = s[127 - 8*(4*c + r) -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) acc = acc ^ gfMul(coef[j], col[(r + j) % 4]);
                res[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dataIn = rand128(); decrypt = 1'(i);
            tick();
            checks++;
            if (dataOut !== 128'h0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: dataOut=%h out_valid=%b, want 0/0", i, dataOut, out_valid);
            end
        end
        rst = 1'b0; in_valid = 1'b0; dataIn = rand128();
        tick();
        checks++;
        if (dataOut !== 128'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: dataOut=%h out_valid=%b, want 0/0", dataOut, out_valid);
        end
    endtask

    task automatic test_vectors();
        in_valid = 1'b1; decrypt = 1'b0; dataIn = 128'h97ECC3954D904AD8F24CE78C876E46A6;
        tick();
        checks++;
        if (dataOut !== 128'h4C9F42BCA3703AA640D4E4A5473794ED || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL fwd_vector: got %h v=%b, want 4c9f42bca3703aa640d4e4a5473794ed v=1", dataOut, out_valid);
        end
        decrypt = 1'b1; dataIn = 128'h4C9F42BCA3703AA640D4E4A5473794ED;
        tick();
        checks++;
        if (dataOut !== 128'h97ECC3954D904AD8F24CE78C876E46A6 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL inv_vector: got %h v=%b, want 97ecc3954d904ad8f24ce78c876e46a6 v=1", dataOut, out_valid);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_columns();
        logic [127:0] stIn, want;
        in_valid = 1'b1;
        for (int dir = 0; dir < 2; dir++) begin
            for (int pos = 0; pos < 4; pos++) begin
                stIn = {4{32'h01010101}};
                want = {4{32'h01010101}};
                stIn[127 - 32*pos -: 32] = dir == 0 ? 32'hDB135345 : 32'h8E4DA1BC;
                want[127 - 32*pos -: 32] = dir == 0 ? 32'h8E4DA1BC : 32'hDB135345;
                dataIn = stIn; decrypt = 1'(dir);
                tick();
                checks++;
                if (dataOut !== want || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL column dir=%0d pos=%0d: got %h v=%b, want %h v=1", dir, pos, dataOut, out_valid, want);
                end
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] want;
        logic [127:0] last;
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; decrypt = 1'(i % 2); dataIn = rand128();
            want = refModel(dataIn, decrypt);
            tick();
            checks++;
            if (dataOut !== want || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream[%0d]: got %h v=%b, want %h v=1", i, dataOut, out_valid, want);
            end
            last = want;
        end
        // Idle cycles with changing decrypt/data must not disturb the held result.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b0; decrypt = ~decrypt; dataIn = rand128();
            tick();
            checks++;
            if (dataOut !== last || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_hold[%0d]: got %h v=%b, want %h v=0", i, dataOut, out_valid, last);
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic [127:0] want;
        in_valid = 1'b1; decrypt = 1'b0; dataIn = rand128();
        tick();
        rst = 1'b1; dataIn = rand128();
        tick();
        checks++;
        if (dataOut !== 128'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset: got %h v=%b, want 0 v=0", dataOut, out_valid);
        end
        rst = 1'b0; decrypt = 1'b1; dataIn = rand128();
        want = refModel(dataIn, 1'b1);
        tick();
        checks++;
        if (dataOut !== want || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_first: got %h v=%b, want %h v=1", dataOut, out_valid, want);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random_roundtrip();
        logic [127:0] orig, fwd;
        for (int i = 0; i < 1000; i++) begin
            orig = rand128();
            in_valid = 1'b1; decrypt = 1'b0; dataIn = orig;
            tick();
            fwd = dataOut;
            checks++;
            if (fwd !== refModel(orig, 1'b0) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rand_fwd[%0d]: got %h v=%b, want %h v=1", i, fwd, out_valid, refModel(orig, 1'b0));
            end
            decrypt = 1'b1; dataIn = fwd;
            tick();
            checks++;
            if (dataOut !== orig || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rand_inv[%0d]: got %h v=%b, want %h v=1", i, dataOut, out_valid, orig);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; in_valid = 1'b0; decrypt = 1'b0; dataIn = '0;
        #2;
        test_reset();
        test_vectors();
        test_columns();
        test_back_to_back();
        test_midstream_reset();
        test_random_roundtrip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
